logic_op_checker: RTL and testbench

Parametrised, self-checking stimulus/response harness for the bitwise-logic operator family (and/or/xor/nand/nor/xnor) in the CI test suite. It drives a deterministic sequence of operand pairs into a DUT, models the expected result internally, and compares it against the DUT output after a configurable pipeline latency. It accumulates an error count and the first failing index, and raises `fail`/`finish` for the CI runner. It replaces per-operator, single-vector, fixed-width test modules with one block covering any width, vector count, operator and DUT latency.

---
 rtl/logic_op_checker.sv | 158 +++++++++++++++
 tb/tb_logic_op_checker.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// logic_op_checker -- drives generated operand pairs into a bitwise-logic DUT,
// models the expected result and checks the DUT after LATENCY cycles. Rev 1.0
// ----------------------------------------------------------------------------
module logic_op_checker #(
   parameter int          WIDTH       = 8,
   parameter int          OP          = 4,
   parameter int          NUM_VECTORS = 16,
   parameter int          LATENCY     = 0,
   parameter logic [63:0] SEED_A      = 64'd7,
   parameter logic [63:0] SEED_B      = 64'd8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   input  logic [WIDTH-1:0] dut_y,
   output logic [WIDTH-1:0] exp_y,
   output logic             busy,
   output logic             fail,
   output logic             finish,
   output logic [15:0]      err_count,
   output logic [15:0]      first_err_idx
);
   localparam int               NV       = (NUM_VECTORS > 65535) ? 65535 : NUM_VECTORS;
   localparam logic [15:0]      LAST_IDX = 16'(NV - 1);
   localparam logic [WIDTH-1:0] A0       = SEED_A[WIDTH-1:0];
   localparam logic [WIDTH-1:0] B0       = SEED_B[WIDTH-1:0];

   generate
      if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
         $error("logic_op_checker: WIDTH must be 2..64");
      end
      if (OP < 0 || OP > 5) begin : g_bad_op
         $error("logic_op_checker: OP must be 0..5");
      end
      if (LATENCY < 0 || LATENCY > 8) begin : g_bad_latency
         $error("logic_op_checker: LATENCY must be 0..8");
      end
      if (NUM_VECTORS < 1) begin : g_bad_count
         $error("logic_op_checker: NUM_VECTORS must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_gen, b_gen, e_cur;
   logic [15:0]      vec_idx, cmp_idx;
   logic [WIDTH-1:0] exp_pipe [0:LATENCY];
   logic [LATENCY:0] vld_pipe;
   logic             launch, drive, last_cmp, mismatch;

   always_comb begin
      case (OP)
         0:       e_cur = a_gen & b_gen;
         1:       e_cur = a_gen | b_gen;
         2:       e_cur = a_gen ^ b_gen;
         3:       e_cur = ~(a_gen & b_gen);
         4:       e_cur = ~(a_gen | b_gen);
         5:       e_cur = ~(a_gen ^ b_gen);
         default: e_cur = '0;
      endcase
   end

   assign exp_y    = exp_pipe[LATENCY];
   assign mismatch = vld_pipe[LATENCY] && (dut_y != exp_pipe[LATENCY]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // DRAIN also covers the final compare edge, so the run ends exactly when
   // the last compare-stage valid bit is consumed.
   always_comb begin
      state_d  = state_q;
      launch   = 1'b0;
      drive    = 1'b0;
      last_cmp = vld_pipe[LATENCY] && (cmp_idx == LAST_IDX);
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               launch  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            drive = 1'b1;
            if (vec_idx == LAST_IDX) state_d = DRAIN;
         end
         DRAIN: begin
            if (last_cmp) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dut_a         <= A0;
         dut_b         <= B0;
         a_gen         <= A0;
         b_gen         <= B0;
         vec_idx       <= '0;
         cmp_idx       <= '0;
         for (int k = 0; k <= LATENCY; k++) exp_pipe[k] <= '0;
         vld_pipe      <= '0;
         busy          <= 1'b0;
         fail          <= 1'b0;
         finish        <= 1'b0;
         err_count     <= '0;
         first_err_idx <= 16'hFFFF;
      end else begin
         if (launch) begin
            a_gen         <= A0;
            b_gen         <= B0;
            vec_idx       <= '0;
            cmp_idx       <= '0;
            fail          <= 1'b0;
            finish        <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 16'hFFFF;
         end
         if (drive) begin
            dut_a       <= a_gen;
            dut_b       <= b_gen;
            exp_pipe[0] <= e_cur;
            a_gen       <= a_gen + 1'b1;
            b_gen       <= {b_gen[WIDTH-2:0], b_gen[WIDTH-1]};
            vec_idx     <= vec_idx + 16'd1;
            busy        <= 1'b1;
         end
         for (int k = 1; k <= LATENCY; k++) begin
            exp_pipe[k] <= exp_pipe[k-1];
            vld_pipe[k] <= vld_pipe[k-1];
         end
         vld_pipe[0] <= drive;
         if (state_q == IDLE || state_q == DONE) vld_pipe <= '0;

         if (vld_pipe[LATENCY]) begin
            cmp_idx <= cmp_idx + 16'd1;
            if (mismatch) begin
               fail <= 1'b1;
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
               if (!fail) first_err_idx <= cmp_idx;
            end
         end
         if (last_cmp) begin
            finish <= 1'b1;
            busy   <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_logic_op_checker.sv
`default_nettype none
// tb_logic_op_checker -- directed runs of several checker configurations against
// bench-side DUT models and a formula-level behavioural model of the checker.
module tb_logic_op_checker;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned nvec = 0, nfail = 0;
   logic rst_m = 1'b0, rst_g = 1'b0, fault_m = 1'b0;
   logic start_m = 1'b0, start_o = 1'b0, start_l = 1'b0, start_s = 1'b0, start_w = 1'b0;

   // main: W8 NOR N16 L0, optionally bit-0-stuck DUT
   logic [7:0] m_opa, m_opb, m_y, m_exp;  logic m_busy, m_fail, m_fin;  logic [15:0] m_err, m_first;
   // one: W8 NOR N1 L0
   logic [7:0] o_opa, o_opb, o_y, o_exp;  logic o_busy, o_fail, o_fin;  logic [15:0] o_err, o_first;
   // lat: W8 NOR N16 L3 with 3-stage DUT
   logic [7:0] l_opa, l_opb, l_y, l_exp;  logic l_busy, l_fail, l_fin;  logic [15:0] l_err, l_first;
   // mis: W8 NOR N16 L2 with 3-stage DUT
   logic [7:0] s_opa, s_opb, s_y, s_exp;  logic s_busy, s_fail, s_fin;  logic [15:0] s_err, s_first;
   // wide: W16 XOR N70000 L0, DUT output stuck at zero
   logic [15:0] w_opa, w_opb, w_y, w_exp; logic w_busy, w_fail, w_fin; logic [15:0] w_err, w_first;

   assign m_y = fault_m ? (~(m_opa | m_opb) & 8'hFE) : ~(m_opa | m_opb);
   assign o_y = ~(o_opa | o_opb);
   assign w_y = '0;
   logic [7:0] l_s1 = '0, l_s2 = '0, l_s3 = '0, s_s1 = '0, s_s2 = '0, s_s3 = '0;
   always @(posedge clk) begin
      l_s1 <= ~(l_opa | l_opb); l_s2 <= l_s1; l_s3 <= l_s2;
      s_s1 <= ~(s_opa | s_opb); s_s2 <= s_s1; s_s3 <= s_s2;
   end
   assign l_y = l_s3;
   assign s_y = s_s3;

   logic_op_checker #(.WIDTH(8), .OP(4), .NUM_VECTORS(16), .LATENCY(0)) u_main (
      .clock(clk), .reset(rst_m), .start(start_m), .dut_a(m_opa), .dut_b(m_opb), .dut_y(m_y),
      .exp_y(m_exp), .busy(m_busy), .fail(m_fail), .finish(m_fin), .err_count(m_err),
      .first_err_idx(m_first));
   logic_op_checker #(.WIDTH(8), .OP(4), .NUM_VECTORS(1), .LATENCY(0)) u_one (
      .clock(clk), .reset(rst_g), .start(start_o), .dut_a(o_opa), .dut_b(o_opb), .dut_y(o_y),
      .exp_y(o_exp), .busy(o_busy), .fail(o_fail), .finish(o_fin), .err_count(o_err),
      .first_err_idx(o_first));
   logic_op_checker #(.WIDTH(8), .OP(4), .NUM_VECTORS(16), .LATENCY(3)) u_lat (
      .clock(clk), .reset(rst_g), .start(start_l), .dut_a(l_opa), .dut_b(l_opb), .dut_y(l_y),
      .exp_y(l_exp), .busy(l_busy), .fail(l_fail), .finish(l_fin), .err_count(l_err),
      .first_err_idx(l_first));
   logic_op_checker #(.WIDTH(8), .OP(4), .NUM_VECTORS(16), .LATENCY(2)) u_mis (
      .clock(clk), .reset(rst_g), .start(start_s), .dut_a(s_opa), .dut_b(s_opb), .dut_y(s_y),
      .exp_y(s_exp), .busy(s_busy), .fail(s_fail), .finish(s_fin), .err_count(s_err),
      .first_err_idx(s_first));
   logic_op_checker #(.WIDTH(16), .OP(2), .NUM_VECTORS(70000), .LATENCY(0)) u_wide (
      .clock(clk), .reset(rst_g), .start(start_w), .dut_a(w_opa), .dut_b(w_opb), .dut_y(w_y),
      .exp_y(w_exp), .busy(w_busy), .fail(w_fail), .finish(w_fin), .err_count(w_err),
      .first_err_idx(w_first));

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint unsigned msk(input int w);
      if (w >= 64) return '1;
      return (64'd1 << w) - 64'd1;
   endfunction
   function automatic longint unsigned vec_a(input int w, input longint unsigned s, input int i);
      return (s + longint'(i)) & msk(w);
   endfunction
   function automatic longint unsigned vec_b(input int w, input longint unsigned s, input int i);
      int r;
      longint unsigned v;
      r = i % w;
      v = s & msk(w);
      if (r == 0) return v;
      return ((v << r) | (v >> (w - r))) & msk(w);
   endfunction
   function automatic longint unsigned vec_e(input int w, input int op,
                                             input longint unsigned a, input longint unsigned b);
      longint unsigned r;
      case (op)
         0: r = a & b;
         1: r = a | b;
         2: r = a ^ b;
         3: r = ~(a & b);
         4: r = ~(a | b);
         default: r = ~(a ^ b);
      endcase
      return r & msk(w);
   endfunction

   // Model channels: 0 = u_main, 1 = u_lat (both W8, NOR, seeds 7/8, N16)
   int m_lat [2] = '{0, 3};
   bit m_act [2] = '{1'b0, 1'b0};
   int m_e0 [2];
   int m_pref [2][17];
   int m_firstbad [2];

   task automatic model_prep(input int ch, input bit faulty);
      longint unsigned e;
      m_e0[ch] = cyc + 1;
      m_pref[ch][0] = 0;
      m_firstbad[ch] = 65535;
      for (int i = 0; i < 16; i++) begin
         e = vec_e(8, 4, vec_a(8, 7, i), vec_b(8, 8, i));
         m_pref[ch][i+1] = m_pref[ch][i] + ((faulty && e[0]) ? 1 : 0);
         if (faulty && e[0] && m_firstbad[ch] == 65535) m_firstbad[ch] = i;
      end
      m_act[ch] = 1'b1;
   endtask

   task automatic launch_main(input bit faulty);
      fault_m = faulty;
      model_prep(0, faulty);
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
   endtask

   // Per-cycle compare of u_main / u_lat against the model
   int cp_t, cp_l, cp_done, cp_k;
   logic [7:0] g_opa, g_opb, g_exp;
   logic g_busy, g_fail, g_fin;
   logic [15:0] g_err, g_first;
   string cp_p;
   initial forever begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
         if (m_act[ch]) begin
            cp_t = cyc - m_e0[ch];
            if (cp_t >= 0) begin
               if (ch == 0) begin
                  g_opa = m_opa; g_opb = m_opb; g_exp = m_exp; g_busy = m_busy;
                  g_fail = m_fail; g_fin = m_fin; g_err = m_err; g_first = m_first; cp_p = "main";
               end else begin
                  g_opa = l_opa; g_opb = l_opb; g_exp = l_exp; g_busy = l_busy;
                  g_fail = l_fail; g_fin = l_fin; g_err = l_err; g_first = l_first; cp_p = "lat";
               end
               cp_l = m_lat[ch];
               cp_done = cp_t - 1 - cp_l;
               if (cp_done < 0) cp_done = 0;
               if (cp_done > 16) cp_done = 16;
               chk({cp_p, ".busy"}, 64'(g_busy), 64'(cp_t >= 1 && cp_t <= 16 + cp_l));
               chk({cp_p, ".finish"}, 64'(g_fin), 64'(cp_t >= 17 + cp_l));
               chk({cp_p, ".err_count"}, 64'(g_err), 64'(m_pref[ch][cp_done]));
               chk({cp_p, ".fail"}, 64'(g_fail), 64'(m_pref[ch][cp_done] != 0));
               chk({cp_p, ".first_err_idx"}, 64'(g_first),
                   64'((m_firstbad[ch] < cp_done) ? m_firstbad[ch] : 65535));
               if (cp_t >= 1) begin
                  cp_k = (cp_t - 1 > 15) ? 15 : cp_t - 1;
                  chk({cp_p, ".dut_a"}, 64'(g_opa), vec_a(8, 7, cp_k));
                  chk({cp_p, ".dut_b"}, 64'(g_opb), vec_b(8, 8, cp_k));
               end
               if (cp_t >= 1 + cp_l && cp_t <= 16 + cp_l) begin
                  cp_k = cp_t - 1 - cp_l;
                  chk({cp_p, ".exp_y"}, 64'(g_exp), vec_e(8, 4, vec_a(8, 7, cp_k), vec_b(8, 8, cp_k)));
               end
            end
         end
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1, "watchdog");
   end

   int w_e0, w_cnt, w_first_exp, l_busy_n, l_fin_t;
   initial begin
      repeat (2) @(negedge clk);
      chk("rst.dut_a", 64'(m_opa), 64'd7);
      chk("rst.dut_b", 64'(m_opb), 64'd8);
      chk("rst.exp_y", 64'(m_exp), 64'd0);
      chk("rst.busy", 64'(m_busy), 64'd0);
      chk("rst.fail", 64'(m_fail), 64'd0);
      chk("rst.finish", 64'(m_fin), 64'd0);
      chk("rst.err_count", 64'(m_err), 64'd0);
      chk("rst.first_err_idx", 64'(m_first), 64'hFFFF);
      chk("rst.wide_dut_b", 64'(w_opb), 64'd8);
      rst_m = 1'b1;
      rst_g = 1'b1;
      @(negedge clk);
      fork
         begin
            w_e0 = cyc + 1;
            start_w = 1'b1;
            @(negedge clk);
            start_w = 1'b0;
            while (!w_fin && (cyc - w_e0) < 70000) @(negedge clk);
            chk("wide.finish_edge", 64'(cyc - w_e0), 64'd65536);
            w_cnt = 0;
            w_first_exp = 65535;
            for (int i = 0; i < 65535; i++) begin
               if (vec_e(16, 2, vec_a(16, 7, i), vec_b(16, 8, i)) != 0) begin
                  w_cnt++;
                  if (w_first_exp == 65535) w_first_exp = i;
               end
            end
            chk("wide.err_count", 64'(w_err), 64'((w_cnt > 65535) ? 65535 : w_cnt));
            chk("wide.first_err_idx", 64'(w_first), 64'(w_first_exp));
            chk("wide.fail", 64'(w_fail), 64'd1);
            chk("wide.dut_a_wrap", 64'(w_opa), 64'h0005);
            chk("wide.dut_b_rot", 64'(w_opb), 64'h0002);
            start_w = 1'b1;
            @(negedge clk);
            start_w = 1'b0;
            chk("wide.restart_fail", 64'(w_fail), 64'd0);
            chk("wide.restart_finish", 64'(w_fin), 64'd0);
            chk("wide.restart_err", 64'(w_err), 64'd0);
            chk("wide.restart_first", 64'(w_first), 64'hFFFF);
            chk("wide.restart_busy0", 64'(w_busy), 64'd0);
            @(negedge clk);
            chk("wide.restart_busy1", 64'(w_busy), 64'd1);
            chk("wide.restart_dut_a", 64'(w_opa), 64'd7);
         end
         begin
            // single-vector run
            start_o = 1'b1;
            @(negedge clk);
            start_o = 1'b0;
            @(negedge clk);
            chk("one.dut_a", 64'(o_opa), 64'd7);
            chk("one.dut_b", 64'(o_opb), 64'd8);
            chk("one.exp_y", 64'(o_exp), 64'hF0);
            chk("one.finish_early", 64'(o_fin), 64'd0);
            @(negedge clk);
            chk("one.finish", 64'(o_fin), 64'd1);
            chk("one.fail", 64'(o_fail), 64'd0);
            chk("one.err_count", 64'(o_err), 64'd0);
            chk("one.first_err_idx", 64'(o_first), 64'hFFFF);

            // clean 16-vector run
            launch_main(1'b0);
            repeat (2) @(negedge clk);
            chk("main.v1_dut_a", 64'(m_opa), 64'd8);
            chk("main.v1_dut_b", 64'(m_opb), 64'd16);
            chk("main.v1_exp_y", 64'(m_exp), 64'hE7);
            repeat (14) @(negedge clk);
            chk("main.finish_t16", 64'(m_fin), 64'd0);
            @(negedge clk);
            chk("main.finish_t17", 64'(m_fin), 64'd1);
            chk("main.clean_fail", 64'(m_fail), 64'd0);
            repeat (2) @(negedge clk);

            // bit-0-stuck DUT: mismatches at i = 1,3,7,9,11,15
            launch_main(1'b1);
            repeat (19) @(negedge clk);
            chk("main.fault_fail", 64'(m_fail), 64'd1);
            chk("main.fault_err_count", 64'(m_err), 64'd6);
            chk("main.fault_first_idx", 64'(m_first), 64'd1);

            // asynchronous reset in the middle of a run
            launch_main(1'b0);
            repeat (5) @(negedge clk);
            m_act[0] = 1'b0;
            rst_m = 1'b0;
            #1;
            chk("abort.dut_a", 64'(m_opa), 64'd7);
            chk("abort.dut_b", 64'(m_opb), 64'd8);
            chk("abort.exp_y", 64'(m_exp), 64'd0);
            chk("abort.busy", 64'(m_busy), 64'd0);
            chk("abort.finish", 64'(m_fin), 64'd0);
            chk("abort.err_count", 64'(m_err), 64'd0);
            chk("abort.first_err_idx", 64'(m_first), 64'hFFFF);
            @(negedge clk);
            rst_m = 1'b1;
            repeat (2) @(negedge clk);
            chk("abort.no_finish", 64'(m_fin), 64'd0);
            launch_main(1'b0);
            repeat (18) @(negedge clk);
            chk("abort.rerun_finish", 64'(m_fin), 64'd1);

            // matched latency 3
            model_prep(1, 1'b0);
            start_l = 1'b1;
            @(negedge clk);
            start_l = 1'b0;
            l_busy_n = 0;
            l_fin_t = -1;
            for (int t = 1; t <= 25; t++) begin
               @(negedge clk);
               if (l_busy) l_busy_n++;
               if (l_fin && l_fin_t < 0) l_fin_t = t;
            end
            chk("lat.busy_cycles", 64'(l_busy_n), 64'd19);
            chk("lat.finish_t", 64'(l_fin_t), 64'd20);
            chk("lat.fail", 64'(l_fail), 64'd0);

            // latency parameter one short of the DUT depth
            start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0;
            repeat (25) @(negedge clk);
            chk("mis.finish", 64'(s_fin), 64'd1);
            chk("mis.fail", 64'(s_fail), 64'd1);
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
`default_nettype wire
